// File: rtl/latch_bank_rf_if.sv
// Write/read/clear bus of the latch_bank_rf storage bank.
// The master drives requests; the slave (the bank) returns status and read data.
interface latch_bank_rf_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
);
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_hit;
    logic             clr;
    logic             busy;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output rd_addr,
        output clr,
        input  wr_ready,
        input  wr_err,
        input  rd_data,
        input  rd_hit,
        input  busy
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        input  clr,
        output wr_ready,
        output wr_err,
        output rd_data,
        output rd_hit,
        output busy
    );
endinterface

// File: rtl/latch_bank_rf.sv
// Flop-based storage bank: DEPTH x WIDTH entries, one write port, one registered read
// port, per-entry valid bits and a sweeper that fills every entry with INIT_VAL after
// reset or a bulk-clear request. BYPASS=1 makes a same-cycle write visible to the read.
module latch_bank_rf #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 16,
    parameter bit               BYPASS   = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input logic            clk_i,
    input logic            rst_i,
    latch_bank_rf_if.slave rf_if
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    // DEPTH widened by one bit so address range checks work for power-of-2 depths too.
    localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic {
        StSweep,
        StReady
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_hit_q, rd_hit_d;
    logic             wr_err_q, wr_err_d;

    logic wr_ready;
    logic wr_fire;
    logic wr_in_range;
    logic rd_in_range;
    logic clear_all;
    logic same_addr;

    // Handshake and address qualification.
    always_comb begin
        wr_ready    = (state_q == StReady) && !rf_if.clr;
        wr_fire     = rf_if.wr_valid && wr_ready;
        wr_in_range = {1'b0, rf_if.wr_addr} < DepthW;
        rd_in_range = {1'b0, rf_if.rd_addr} < DepthW;
        clear_all   = (state_q == StReady) && rf_if.clr;
        same_addr   = rf_if.wr_addr == rf_if.rd_addr;
    end

    // Sweep/ready sequencing; CLR only matters once the sweep has finished.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StSweep: begin
                if (ptr_q == LastIdx) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            StReady: begin
                if (rf_if.clr) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // State register and sweep pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StSweep;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Valid bits: cleared in bulk, set by accepted in-range writes.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (wr_fire && wr_in_range) begin
            valid_d[rf_if.wr_addr] = 1'b1;
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Storage array; no reset because the sweeper initialises every entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StSweep) begin
                mem_q[ptr_q] <= INIT_VAL;
            end else if (wr_fire && wr_in_range) begin
                mem_q[rf_if.wr_addr] <= rf_if.wr_data;
            end
        end
    end

    // Read mux: zero while sweeping or out of range, optional write-through otherwise.
    always_comb begin
        rd_data_d = '0;
        rd_hit_d  = 1'b0;
        wr_err_d  = wr_fire && !wr_in_range;
        if ((state_q == StReady) && rd_in_range) begin
            if (BYPASS && wr_fire && wr_in_range && same_addr) begin
                rd_data_d = rf_if.wr_data;
                rd_hit_d  = 1'b1;
            end else begin
                rd_data_d = mem_q[rf_if.rd_addr];
                rd_hit_d  = valid_q[rf_if.rd_addr];
            end
        end
    end

    // Registered read data, hit flag and write-error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign rf_if.wr_ready = wr_ready;
    assign rf_if.wr_err   = wr_err_q;
    assign rf_if.rd_data  = rd_data_q;
    assign rf_if.rd_hit   = rd_hit_q;
    assign rf_if.busy     = (state_q == StSweep);

endmodule

// File: tb/tb_latch_bank_rf.sv
// Bench for latch_bank_rf: two instances (DEPTH=16 write-through, DEPTH=12 no bypass
// with a non-zero fill value) driven by the same stimulus and checked against an
// array-based model of the bank.
module tb_latch_bank_rf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_valid;
    logic       clr;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;

    latch_bank_rf_if #(.WIDTH(8), .AW(4)) bus0 ();
    latch_bank_rf_if #(.WIDTH(8), .AW(4)) bus1 ();

    assign bus0.wr_valid = wr_valid;
    assign bus0.wr_addr  = wr_addr;
    assign bus0.wr_data  = wr_data;
    assign bus0.rd_addr  = rd_addr;
    assign bus0.clr      = clr;
    assign bus1.wr_valid = wr_valid;
    assign bus1.wr_addr  = wr_addr;
    assign bus1.wr_data  = wr_data;
    assign bus1.rd_addr  = rd_addr;
    assign bus1.clr      = clr;

    latch_bank_rf #(
        .WIDTH(8), .DEPTH(16), .BYPASS(1'b1), .INIT_VAL(8'h00)
    ) dut0 (
        .clk_i(clk),
        .rst_i(rst),
        .rf_if(bus0)
    );

    latch_bank_rf #(
        .WIDTH(8), .DEPTH(12), .BYPASS(1'b0), .INIT_VAL(8'h3C)
    ) dut1 (
        .clk_i(clk),
        .rst_i(rst),
        .rf_if(bus1)
    );

    logic [7:0] o_rd   [2];
    logic       o_hit  [2];
    logic       o_err  [2];
    logic       o_busy [2];
    logic       o_rdy  [2];

    assign o_rd[0]   = bus0.rd_data;
    assign o_hit[0]  = bus0.rd_hit;
    assign o_err[0]  = bus0.wr_err;
    assign o_busy[0] = bus0.busy;
    assign o_rdy[0]  = bus0.wr_ready;
    assign o_rd[1]   = bus1.rd_data;
    assign o_hit[1]  = bus1.rd_hit;
    assign o_err[1]  = bus1.wr_err;
    assign o_busy[1] = bus1.busy;
    assign o_rdy[1]  = bus1.wr_ready;

    // Reference model: plain arrays plus a count of remaining sweep cycles.
    int         m_depth [2] = '{16, 12};
    bit         m_byp   [2] = '{1'b1, 1'b0};
    logic [7:0] m_init  [2] = '{8'h00, 8'h3C};
    int         m_left  [2] = '{0, 0};
    logic [7:0] m_mem   [2][16];
    bit         m_vld   [2][16];
    logic [7:0] e_rd    [2];
    bit         e_hit   [2];
    bit         e_err   [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit busy, fire, inr, rinr;
            busy = m_left[k] > 0;
            fire = wr_valid && !busy && !clr;
            inr  = int'(wr_addr) < m_depth[k];
            rinr = int'(rd_addr) < m_depth[k];
            if (rst) begin
                m_left[k] = m_depth[k];
                for (int i = 0; i < 16; i++) begin
                    m_vld[k][i] = 1'b0;
                    m_mem[k][i] = m_init[k];
                end
                e_rd[k]  = 8'h00;
                e_hit[k] = 1'b0;
                e_err[k] = 1'b0;
            end else begin
                e_err[k] = fire && !inr;
                if (busy || !rinr) begin
                    e_rd[k]  = 8'h00;
                    e_hit[k] = 1'b0;
                end else if (m_byp[k] && fire && inr && wr_addr == rd_addr) begin
                    e_rd[k]  = wr_data;
                    e_hit[k] = 1'b1;
                end else begin
                    e_rd[k]  = m_mem[k][rd_addr];
                    e_hit[k] = m_vld[k][rd_addr];
                end
                if (busy) begin
                    m_left[k] = m_left[k] - 1;
                end else if (clr) begin
                    m_left[k] = m_depth[k];
                    for (int i = 0; i < 16; i++) begin
                        m_vld[k][i] = 1'b0;
                        m_mem[k][i] = m_init[k];
                    end
                end else if (fire && inr) begin
                    m_mem[k][wr_addr] = wr_data;
                    m_vld[k][wr_addr] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic c, input logic [3:0] wa,
                         input logic [7:0] wd, input logic [3:0] ra);
        rst      = r;
        wr_valid = v;
        clr      = c;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr  = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        for (int c = 0; c < 18; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (o_busy[k] !== (c < m_depth[k]) || o_rdy[k] !== !(c < m_depth[k])) begin
                    n_fail++;
                    $display("FAIL reset_busy dut%0d cyc%0d: busy=%b ready=%b, want busy=%b",
                             k, c, o_busy[k], o_rdy[k], c < m_depth[k]);
                end
            end
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'(a));
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [7:0] want;
                want = (a < m_depth[k]) ? m_init[k] : 8'h00;
                n_tests++;
                if (o_rd[k] !== want || o_hit[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_read dut%0d addr%0d: got %h/%b want %h/0",
                             k, a, o_rd[k], o_hit[k], want);
                end
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_rd[k] !== 8'hA5 || o_hit[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL write_read dut%0d: got %h/%b want a5/1", k, o_rd[k], o_hit[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] want [2];
        drive(1'b0, 1'b1, 1'b0, 4'd5, 8'h11, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 4'd5, 8'h22, 4'd5);
        tick();
        want[0] = 8'h22;
        want[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_rd[k] !== want[k] || o_hit[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_same dut%0d: got %h/%b want %h/1",
                         k, o_rd[k], o_hit[k], want[k]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd5);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_rd[k] !== 8'h22 || o_hit[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_reread dut%0d: got %h/%b want 22/1", k, o_rd[k], o_hit[k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 1'b1, 1'b0, 4'd13, 8'h77, 4'd0);
        tick();
        n_tests++;
        if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_err_pulse: dut0=%b dut1=%b want 0/1", o_err[0], o_err[1]);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd14);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_err[k] !== 1'b0 || o_rd[k] !== 8'h00 || o_hit[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_read dut%0d: err=%b rd=%h hit=%b want 0/00/0",
                         k, o_err[k], o_rd[k], o_hit[k]);
            end
        end
        for (int a = 0; a < 12; a++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'(a));
            tick();
            n_tests++;
            if (o_rd[1] !== e_rd[1] || o_hit[1] !== e_hit[1]) begin
                n_fail++;
                $display("FAIL oor_unchanged addr%0d: got %h/%b want %h/%b",
                         a, o_rd[1], o_hit[1], e_rd[1], e_hit[1]);
            end
        end
    endtask

    task automatic test_clr_vs_write();
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'h5A, 4'd3);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_rdy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_ready dut%0d: got %b want 0", k, o_rdy[k]);
            end
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3);
        for (int c = 0; c < 17; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (o_busy[k] !== (c < m_depth[k])) begin
                    n_fail++;
                    $display("FAIL clr_busy dut%0d cyc%0d: got %b want %b",
                             k, c, o_busy[k], c < m_depth[k]);
                end
            end
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'(a));
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [7:0] want;
                want = (a < m_depth[k]) ? m_init[k] : 8'h00;
                n_tests++;
                if (o_rd[k] !== want || o_hit[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clr_read dut%0d addr%0d: got %h/%b want %h/0",
                             k, a, o_rd[k], o_hit[k], want);
                end
            end
        end
    endtask

    task automatic test_rst_mid_sweep();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        for (int c = 0; c < 5; c++) tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        for (int c = 0; c < 18; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (o_busy[k] !== (c < m_depth[k])) begin
                    n_fail++;
                    $display("FAIL rst_restart dut%0d cyc%0d: got %b want %b",
                             k, c, o_busy[k], c < m_depth[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(15));
            drive(($urandom_range(99) == 0), 1'($urandom_range(1)), ($urandom_range(29) == 0),
                  wa, 8'($urandom), ($urandom_range(2) == 0) ? wa : 4'($urandom_range(15)));
            tick();
            for (int k = 0; k < 2; k++) begin
                bit want_busy;
                want_busy = m_left[k] > 0;
                n_tests++;
                if (o_rd[k] !== e_rd[k] || o_hit[k] !== e_hit[k] || o_err[k] !== e_err[k] ||
                    o_busy[k] !== want_busy || o_rdy[k] !== (!want_busy && !clr)) begin
                    n_fail++;
                    $display("FAIL random dut%0d step%0d: rd=%h hit=%b err=%b busy=%b rdy=%b want %h/%b/%b/%b/%b",
                             k, n, o_rd[k], o_hit[k], o_err[k], o_busy[k], o_rdy[k],
                             e_rd[k], e_hit[k], e_err[k], want_busy, !want_busy && !clr);
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        test_reset();
        test_write_read();
        test_bypass();
        test_out_of_range();
        test_clr_vs_write();
        test_rst_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
